// File: rtl/debugger_tx_serializer.sv
// Transmit end of the debugger link: latches one wide debug frame and feeds it
// MSB byte first into the UART transmitter, then pulses data_sent once.
module debugger_tx_serializer #(
  parameter int NUM_BYTES = 220,
  parameter int CNT_W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   send_signal,
  input  logic [8*NUM_BYTES-1:0] send_data,
  input  logic                   tx_done_tick,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   data_sent,
  output logic                   busy,
  output logic [CNT_W-1:0]       bytes_left
);

  // Handshakes: send_signal is a request honoured only in IDLE (never queued);
  // tx_start is a one-cycle load strobe, and the UART answers each one with a
  // one-cycle tx_done_tick that is consumed only while waiting for it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_BYTES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [8*NUM_BYTES-1:0] shadow;
  logic [CNT_W-1:0]       idx;
  logic                   accept;
  logic                   byte_done;
  logic                   last_byte;

  assign accept    = (state == IDLE) && send_signal;
  assign byte_done = (state == WAIT) && tx_done_tick;
  assign last_byte = (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (send_signal) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (tx_done_tick) state_next = last_byte ? DONE : START;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow     <= '0;
      idx        <= '0;
      bytes_left <= '0;
    end else if (accept) begin
      shadow     <= send_data;
      idx        <= '0;
      bytes_left <= FRAME_LEN;
    end else if (byte_done) begin
      bytes_left <= bytes_left - CNT_W'(1);
      if (!last_byte) begin
        idx    <= idx + CNT_W'(1);
        shadow <= shadow << 8;
      end
    end
  end

  always_comb begin
    tx_start  = (state == START);
    data_sent = (state == DONE);
    busy      = (state != IDLE);
  end

  // The current byte always sits at the top of the shadow register, so tx_data
  // is already valid in the tx_start cycle and holds until the next shift.
  assign tx_data = shadow[8*NUM_BYTES-1 -: 8];

endmodule

// File: tb/tb_debugger_tx_serializer.sv
// Bench for debugger_tx_serializer: table of frame vectors plus hand-written
// sequences for reset, spurious ticks, mid-frame reset and back-to-back frames.
module tb_debugger_tx_serializer;

  localparam int NB = 220;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          send_signal = 1'b0;
  logic [8*NB-1:0] send_data = '0;
  logic          manual_tick = 1'b0;
  logic          auto_tick = 1'b0;
  logic          tx_done_tick;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          data_sent;
  logic          busy;
  logic [CW-1:0] bytes_left;

  assign tx_done_tick = manual_tick | auto_tick;

  debugger_tx_serializer #(.NUM_BYTES(NB), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .send_signal  (send_signal),
    .send_data    (send_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .data_sent    (data_sent),
    .busy         (busy),
    .bytes_left   (bytes_left)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] fill;
    logic [7:0] last;
    int         reject_at;
    bit         spur_start;
    int         exp_starts;
    int         exp_sent;
  } vec_t;

  vec_t        vecs[3];
  logic [15:0] obs_q[$];
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_start = 0;
  int          n_sent = 0;
  int          unstable = 0;
  int          sent_untimely = 0;
  logic        in_byte = 1'b0;
  logic [7:0]  held = 8'h00;
  int          cd = 0;

  // Clock
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // UART model: done tick ten cycles after each tx_start.
  always @(negedge clock) begin
    #2;
    auto_tick = 1'b0;
    if (reset) cd = 0;
    else if (tx_start) cd = 10;
    else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) auto_tick = 1'b1;
    end
  end

  // Monitor: a tick visible at this negedge was sampled at the preceding edge.
  always @(negedge clock) begin
    if (reset) begin
      in_byte = 1'b0;
    end else begin
      if (tx_done_tick) in_byte = 1'b0;
      if (data_sent) begin
        n_sent = n_sent + 1;
        if (!tx_done_tick) sent_untimely = sent_untimely + 1;
      end
      if (tx_start) begin
        obs_q.push_back({tx_data, bytes_left});
        n_start = n_start + 1;
        in_byte = 1'b1;
        held    = tx_data;
      end else if (in_byte && tx_data !== held) begin
        unstable = unstable + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic build(input logic [7:0] b0, input logic [7:0] fill, input logic [7:0] last,
                       output logic [8*NB-1:0] d);
    for (int i = 0; i < NB; i++)
      d[8*(NB-1-i) +: 8] = (i == 0) ? b0 : ((i == NB-1) ? last : fill);
  endtask

  task automatic start_frame(input logic [8*NB-1:0] d, input bit spur);
    for (int i = 0; i < NB; i++) exp_q.push_back(d[8*(NB-1-i) +: 8]);
    send_data   = d;
    send_signal = 1'b1;
    step();
    send_signal = 1'b0;
    check("start_latency", tx_start, 1);
    check("busy_on_accept", busy, 1);
    check("bytes_left_load", bytes_left, NB);
    if (spur) begin
      manual_tick = 1'b1;
      step();
      manual_tick = 1'b0;
      check("spur_start_bytes_left", bytes_left, NB);
      check("spur_start_no_restart", tx_start, 0);
    end
  endtask

  task automatic finish_frame(input logic [8*NB-1:0] d, input int reject_at);
    int s0;
    int budget;
    int k;
    bit rejected;
    logic [15:0] o;
    logic [7:0]  e;
    s0 = n_sent;
    budget = 0;
    rejected = 1'b0;
    while (n_sent == s0 && budget < 4000) begin
      if (!rejected && reject_at >= 0 && obs_q.size() > reject_at) begin
        send_data   = ~d;
        send_signal = 1'b1;
        rejected    = 1'b1;
      end
      step();
      send_signal = 1'b0;
      budget++;
    end
    check("frame_done_in_time", n_sent != s0, 1);
    check("data_sent_in_done", data_sent, 1);
    check("busy_in_done", busy, 1);
    check("bytes_left_zero", bytes_left, 0);
    check("tx_start_count", obs_q.size(), NB);
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("byte_value", o[15:8], e);
      check("bytes_left_at_start", o[7:0], NB - k);
      k++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [8*NB-1:0] d;
    logic [8*NB-1:0] d2;
    int base_sent;
    int base_start;
    int b;

    vecs[0] = '{8'h01, 8'hA5, 8'hFF, -1, 1'b0, NB, 1};
    vecs[1] = '{8'h3C, 8'h00, 8'hC3,  5, 1'b0, NB, 1};
    vecs[2] = '{8'hFF, 8'h5A, 8'h80, -1, 1'b1, NB, 1};

    // Reset held with a pending request
    reset       = 1'b1;
    send_signal = 1'b1;
    send_data   = '1;
    repeat (3) step();
    check("reset_tx_start", tx_start, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_data_sent", data_sent, 0);
    check("reset_busy", busy, 0);
    check("reset_bytes_left", bytes_left, 0);
    check("reset_no_starts", n_start, 0);
    send_signal = 1'b0;
    reset       = 1'b0;
    step();

    // Spurious tick in IDLE
    manual_tick = 1'b1;
    step();
    manual_tick = 1'b0;
    step();
    check("idle_tick_busy", busy, 0);
    check("idle_tick_bytes_left", bytes_left, 0);
    check("idle_tick_no_start", tx_start, 0);

    for (int v = 0; v < 3; v++) begin
      base_sent  = n_sent;
      base_start = n_start;
      build(vecs[v].b0, vecs[v].fill, vecs[v].last, d);
      start_frame(d, vecs[v].spur_start);
      finish_frame(d, vecs[v].reject_at);
      step();
      check("data_sent_pulse", data_sent, 0);
      check("busy_after_done", busy, 0);
      repeat (20) step();
      check("sent_count", n_sent - base_sent, vecs[v].exp_sent);
      check("start_count", n_start - base_start, vecs[v].exp_starts);
    end

    // Reset after byte 100's tx_start
    base_sent  = n_sent;
    base_start = n_start;
    build(8'h11, 8'h22, 8'h33, d);
    start_frame(d, 1'b0);
    b = 0;
    while (obs_q.size() < 101 && b < 5000) begin
      step();
      b++;
    end
    check("reached_byte_100", obs_q.size(), 101);
    reset = 1'b1;
    step();
    check("midreset_tx_start", tx_start, 0);
    check("midreset_tx_data", tx_data, 0);
    check("midreset_busy", busy, 0);
    check("midreset_bytes_left", bytes_left, 0);
    check("midreset_data_sent", data_sent, 0);
    step();
    reset = 1'b0;
    repeat (30) step();
    check("midreset_no_sent", n_sent - base_sent, 0);
    check("midreset_starts", n_start - base_start, 101);
    obs_q.delete();
    exp_q.delete();

    // Fresh frame, then request in DONE (ignored) and back-to-back in IDLE
    build(8'h77, 8'h88, 8'h99, d);
    start_frame(d, 1'b0);
    finish_frame(d, -1);
    build(8'hC0, 8'h0F, 8'hE1, d2);
    send_data   = ~d2;
    send_signal = 1'b1;
    step();
    send_signal = 1'b0;
    check("done_send_ignored_busy", busy, 0);
    check("done_send_ignored_start", tx_start, 0);
    base_sent  = n_sent;
    base_start = n_start;
    start_frame(d2, 1'b0);
    finish_frame(d2, -1);
    step();
    repeat (20) step();
    check("b2b_sent_count", n_sent - base_sent, 1);
    check("b2b_start_count", n_start - base_start, NB);

    check("tx_data_stable", unstable, 0);
    check("data_sent_after_last_tick", sent_untimely, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
